// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, rx_done / frame_err strobes.
// Optional 2-of-3 majority sampling is enabled by defining UART_RX_MAJORITY_EN.
module uart_rx #(
    parameter int BIT_PERIOD = 867
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rx_done,
    output logic       frame_err
);

    localparam logic [15:0] BP_C   = 16'(BIT_PERIOD);
    localparam logic [15:0] HALF_C = 16'(BIT_PERIOD / 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t      state_r;
    logic        rx_meta_r;
    logic        rx_s;
    logic [15:0] counter;
    logic [2:0]  bit_idx_r;
    logic [7:0]  shift_r;
    logic        sample_s;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Two-flop synchroniser for the asynchronous rx pin
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s      <= rx_meta_r;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [15:0] point_s;
    logic [1:0]  hist_r;

    // Sample point: half bit while validating the start bit, full bit otherwise
    always_comb begin
        if (state_r == START) begin
            point_s = HALF_C;
        end else begin
            point_s = BP_C;
        end
    end

    // Capture the two samples preceding the sample point for the vote
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_r <= 2'b11;
        end else if (counter == point_s - 16'd2) begin
            hist_r[0] <= rx_s;
        end else if (counter == point_s - 16'd1) begin
            hist_r[1] <= rx_s;
        end else begin
            hist_r <= hist_r;
        end
    end

    // Majority vote of the three most recent line samples
    always_comb begin
        sample_s = maj3(hist_r[0], hist_r[1], rx_s);
    end
`else
    // Single sample of the synchronised line
    always_comb begin
        sample_s = rx_s;
    end
`endif

    // Receive FSM with registered strobes and data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            counter   <= 16'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            data      <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state_r)
                IDLE: begin
                    counter <= 16'd0;
                    if (!rx_s) begin
                        state_r <= START;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    if (counter == HALF_C) begin
                        counter   <= 16'd0;
                        bit_idx_r <= 3'd0;
                        // A high line at mid-start is a glitch, not a frame
                        if (sample_s) begin
                            state_r <= IDLE;
                        end else begin
                            state_r <= DATA;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end
                DATA: begin
                    if (counter == BP_C) begin
                        counter <= 16'd0;
                        shift_r <= {sample_s, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end
                STOP: begin
                    if (counter == BP_C) begin
                        counter <= 16'd0;
                        if (sample_s) begin
                            data    <= shift_r;
                            rx_done <= 1'b1;
                            state_r <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state_r   <= BREAK;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end
                BREAK: begin
                    // Held-low line: wait for release so only one error is reported
                    counter <= 16'd0;
                    if (rx_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= BREAK;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    counter <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at BIT_PERIOD=15: driver pushes expected strobes,
// a negedge monitor pops and compares kind, data and arrival cycle.
module tb_uart_rx;

    localparam int BP  = 15;
    localparam int T   = BP + 1;
    localparam int H   = BP / 2;
    // Pin edge to strobe: 2 synchroniser cycles + (H+2+9T) after the rx_s edge
    localparam int LAT = H + 4 + 9 * T;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       rx_done;
    logic       frame_err;

    uart_rx #(.BIT_PERIOD(BP)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .rx_done   (rx_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the expectation queue
    always @(negedge clk) begin
        if (rx_done || frame_err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'({rx_done, frame_err}), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_kind", 32'({rx_done, frame_err}), mon_e.is_err ? 32'd1 : 32'd2);
                check("strobe_data", 32'(data), 32'(mon_e.data));
                check("strobe_cycle", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx  = 1'b1;
            rst = 1'b0;
        end
    endtask

    // kind: 0 = no strobe expected, 1 = rx_done, 2 = frame_err
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit glitch,
                              input int rst_at, input int kind, input logic [7:0] exp_data);
        for (int j = 0; j < 10 * T; j++) begin
            int   bi;
            logic v;
            @(negedge clk);
            bi = j / T;
            if (bi == 0) v = 1'b0;
            else if (bi <= 8) v = b[bi-1];
            else v = stop_v;
            if (glitch && bi >= 1 && bi <= 8 && (j % T) == H + 1) v = ~v;
            rx  = v;
            rst = (j == rst_at);
            if (j == 0 && kind != 0) exp_q.push_back('{kind == 2, exp_data, cyc + LAT});
        end
    endtask

    initial begin
        logic [7:0] glitch_exp;
`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 8'h96;
`else
        glitch_exp = 8'h69;
`endif
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", 32'(data), 32'h00);
        check("reset_rx_done", 32'(rx_done), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        idle(20);

        send_frame(8'hA5, 1'b1, 1'b0, -1, 1, 8'hA5);
        idle(20);
        send_frame(8'h00, 1'b1, 1'b0, -1, 1, 8'h00);
        send_frame(8'hFF, 1'b1, 1'b0, -1, 1, 8'hFF);
        idle(20);

        // Short low pulse: start validation must reject it
        repeat (3) begin
            @(negedge clk);
            rx = 1'b0;
        end
        idle(40);
        check("glitch_data_held", 32'(data), 32'hFF);
        send_frame(8'h3C, 1'b1, 1'b0, -1, 1, 8'h3C);
        idle(20);

        // Bad stop bit then a held-low line: exactly one frame_err
        send_frame(8'h55, 1'b0, 1'b0, -1, 2, 8'h3C);
        repeat (40) begin
            @(negedge clk);
            rx = 1'b0;
        end
        idle(20);
        check("break_data_held", 32'(data), 32'h3C);
        send_frame(8'h81, 1'b1, 1'b0, -1, 1, 8'h81);
        idle(20);

        // Reset pulse in the middle of data bit 4
        send_frame(8'hF0, 1'b1, 1'b0, 5 * T + 3, 0, 8'h00);
        idle(20);
        check("rst_data", 32'(data), 32'h00);
        check("rst_rx_done", 32'(rx_done), 32'd0);
        send_frame(8'h12, 1'b1, 1'b0, -1, 1, 8'h12);
        idle(20);

        send_frame(8'h96, 1'b1, 1'b1, -1, 1, glitch_exp);
        idle(40);
        check("pending_expectations", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
